// File: rtl/inst_prefetch_pkg.sv
// Shared constants for the instruction fetch front end: word layout,
// opcode values and the PC value taken on reset.
package inst_prefetch_pkg;

   localparam int WORD = 16;

   localparam logic [3:0] OP_LI      = 4'hF;
   localparam logic [3:0] OP_JZSYSSZ = 4'hE;
   localparam logic [3:0] OP_ST      = 4'hD;
   localparam logic [3:0] OP_LD      = 4'hC;

   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int D_HI  = 11;
   localparam int D_LO  = 6;
   localparam int S_HI  = 5;
   localparam int S_LO  = 0;

   localparam logic [WORD-1:0] RESET_PC = '0;

   function automatic logic isLiOpcode(input logic [WORD-1:0] word);
      return word[OP_HI:OP_LO] == OP_LI;
   endfunction

endpackage

// File: rtl/inst_prefetch_fifo.sv
// Circular prefetch queue of {word, pc, li2}; flush empties it in one cycle
// and the head reads as all zeros while the queue is empty.
module fetch_fifo #(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       enq,
   input  logic                       deq,
   input  logic [WORD_W-1:0]          enqWord,
   input  logic [WORD_W-1:0]          enqPc,
   input  logic                       enqLi2,
   output logic [$clog2(DEPTH):0]     count,
   output logic [WORD_W-1:0]          headWord,
   output logic [WORD_W-1:0]          headPc,
   output logic                       headLi2
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = 2 * WORD_W + 1;

   logic [ENTRY_W-1:0] entryMem [DEPTH];
   logic [PTR_W-1:0]   rdPtr;
   logic [PTR_W-1:0]   wrPtr;
   logic [ENTRY_W-1:0] headEntry;

   // NOTE: storage is deliberately not reset; count gates every read, so stale
   // entries are never visible and the array can map onto plain RAM/flops.
   always_ff @(posedge clock) begin
      if (enq) begin
         entryMem[wrPtr] <= {enqWord, enqPc, enqLi2};
      end
   end

   // Pointers are PTR_W wide, so DEPTH being a power of two makes them wrap.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (enq) wrPtr <= wrPtr + PTR_W'(1);
         if (deq) rdPtr <= rdPtr + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign headEntry = (count != '0) ? entryMem[rdPtr] : '0;
   assign headWord  = headEntry[ENTRY_W-1 -: WORD_W];
   assign headPc    = headEntry[WORD_W:1];
   assign headLi2   = headEntry[0];

endmodule

// File: rtl/inst_prefetch.sv
// Fetch front end: owns the PC, issues 1-cycle-latency reads, tags LI immediates
// and presents one decoded head entry per cycle under valid/ready.
module inst_prefetch
   import inst_prefetch_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [WORD_W-1:0]          imem_addr,
   input  logic [WORD_W-1:0]          imem_data,
   input  logic                       jump_en,
   input  logic [WORD_W-1:0]          jump_addr,
   input  logic                       halt,
   input  logic                       deq_ready,
   output logic                       out_valid,
   output logic [WORD_W-1:0]          out_word,
   output logic [3:0]                 out_op,
   output logic [5:0]                 out_d,
   output logic [5:0]                 out_s,
   output logic [WORD_W-1:0]          out_pc,
   output logic                       out_li2,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(DEPTH);

   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] issuePc;
   logic              inflight;
   logic              liPending;
   logic              issue;
   logic              enq;
   logic              deq;
   logic [CNT_W:0]    occupancy;

   // NOTE: every always_comb output gets a default first so no path can leave
   // a signal unassigned and infer a latch.
   always_comb begin
      occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
      issue     = 1'b0;
      if (!reset && !jump_en && !halt && (occupancy < DEPTH_LIMIT)) begin
         issue = 1'b1;
      end
   end

   // A read returning in a jump cycle belongs to the abandoned stream.
   assign enq       = inflight && !jump_en;
   assign deq       = out_valid && deq_ready && !jump_en;
   assign imem_req  = issue;
   assign imem_addr = pc;
   assign out_valid = (count != '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         pc        <= WORD_W'(RESET_PC);
         issuePc   <= '0;
         inflight  <= 1'b0;
         liPending <= 1'b0;
      end else if (jump_en) begin
         pc        <= jump_addr;
         inflight  <= 1'b0;
         liPending <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc      <= pc + WORD_W'(1);
            issuePc <= pc;
         end
         // The word after an untagged LI is its immediate, never an opcode.
         if (enq) begin
            liPending <= isLiOpcode(imem_data[WORD-1:0]) && !liPending;
         end
      end
   end

   fetch_fifo #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (jump_en),
      .enq      (enq),
      .deq      (deq),
      .enqWord  (imem_data),
      .enqPc    (issuePc),
      .enqLi2   (liPending),
      .count    (count),
      .headWord (out_word),
      .headPc   (out_pc),
      .headLi2  (out_li2)
   );

   assign out_op = out_word[OP_HI:OP_LO];
   assign out_d  = out_word[D_HI:D_LO];
   assign out_s  = out_word[S_HI:S_LO];

endmodule
